// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment patterns {g,f,e,d,c,b,a}
// and the BCD decode used by every display block.
package seven_seg_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal codes blank the digit rather than show a glyph.
    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] bcd);
        case (bcd)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD to seven-segment decoder for one digit.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    assign seg = seg_decode(bcd);

endmodule

// File: rtl/seven_segment_counter_mux.sv
// N-digit up/down BCD counter stepped by a programmable prescaler and
// time-multiplexed onto one shared seven-segment bus.
module seven_segment_counter_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned             NUM_DIGITS      = 4,
    parameter int unsigned             PRESCALE_W      = 24,
    parameter int unsigned             REFRESH_W       = 10,
    parameter logic [PRESCALE_W-1:0]   DEFAULT_COMPARE = PRESCALE_W'(24'd15999999)
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          active,
    input  logic [PRESCALE_W-1:0]         compare_in,
    input  logic                          update_compare,
    input  logic                          count_en,
    input  logic                          count_down,
    input  logic                          clear,
    output logic [6:0]                    led_out,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [BCD_W*NUM_DIGITS-1:0]   bcd_value,
    output logic                          tick
);

    localparam int unsigned DW    = BCD_W * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRESCALE_W-1:0] compare_reg;
    logic [PRESCALE_W-1:0] prescaler;
    logic [DW-1:0]         digits;
    logic [DW-1:0]         next_digits;
    logic                  tick_r;
    logic [REFRESH_W-1:0]  refresh;
    logic [IDX_W-1:0]      index;
    logic [NUM_DIGITS-1:0] lim;
    logic [NUM_DIGITS-1:0] step_in;
    logic [BCD_W-1:0]      cur_digit;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] sel_onehot;

    // A digit steps when every lower digit sits at its wrap limit
    // (9 going up, 0 going down); the prefix AND avoids a ripple loop.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [BCD_W-1:0] d;
        assign d      = digits[g*BCD_W +: BCD_W];
        assign lim[g] = count_down ? (d == 4'd0) : (d == 4'd9);
        if (g == 0) begin : g_lsd
            assign step_in[g] = 1'b1;
        end else begin : g_upper
            assign step_in[g] = &lim[g-1:0];
        end
        assign next_digits[g*BCD_W +: BCD_W] =
            !step_in[g] ? d :
            lim[g]      ? (count_down ? 4'd9 : 4'd0) :
            count_down  ? d - 4'd1 : d + 4'd1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            compare_reg <= DEFAULT_COMPARE;
            prescaler   <= '0;
            digits      <= '0;
            tick_r      <= 1'b0;
        end else if (clear) begin
            digits    <= '0;
            prescaler <= '0;
            tick_r    <= 1'b0;
            if (update_compare) begin
                compare_reg <= compare_in;
            end
        end else if (update_compare) begin
            compare_reg <= compare_in;
            prescaler   <= '0;
            tick_r      <= 1'b0;
        end else if (count_en) begin
            if (prescaler == compare_reg) begin
                prescaler <= '0;
                tick_r    <= 1'b1;
                digits    <= next_digits;
            end else begin
                prescaler <= prescaler + PRESCALE_W'(1);
                tick_r    <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    // Free-running refresh; the digit index moves on each wrap.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            refresh <= '0;
            index   <= '0;
        end else begin
            refresh <= refresh + REFRESH_W'(1);
            if (&refresh) begin
                index <= (index == IDX_W'(NUM_DIGITS - 1)) ? '0 : index + IDX_W'(1);
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (index == IDX_W'(i)) begin
                cur_digit = digits[i*BCD_W +: BCD_W];
            end
        end
    end

    seven_seg_decoder u_decoder (
        .bcd (cur_digit),
        .seg (seg)
    );

    assign sel_onehot = NUM_DIGITS'(1) << index;

    assign led_out   = active ? seg        : '0;
    assign digit_sel = active ? sel_onehot : '0;
    assign bcd_value = active ? digits     : '0;
    assign tick      = active ? tick_r     : 1'b0;

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Directed bench: expected ticks (cycle and count) are queued when stimulus
// is driven and checked by a monitor whenever the DUT raises tick.
module tb_seven_segment_counter_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        active = 1'b1;
    logic [23:0] compare_in = '0;
    logic        update_compare = 1'b0;
    logic        count_en = 1'b0;
    logic        count_down = 1'b0;
    logic        clear = 1'b0;
    logic [6:0]  led_out;
    logic [3:0]  digit_sel;
    logic [15:0] bcd_value;
    logic        tick;

    typedef struct {
        int          at;
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   model_v = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                  7'b1111111, 7'b1101111};

    seven_segment_counter_mux #(
        .NUM_DIGITS      (4),
        .PRESCALE_W      (24),
        .REFRESH_W       (2),
        .DEFAULT_COMPARE (24'd7)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .active         (active),
        .compare_in     (compare_in),
        .update_compare (update_compare),
        .count_en       (count_en),
        .count_down     (count_down),
        .clear          (clear),
        .led_out        (led_out),
        .digit_sel      (digit_sel),
        .bcd_value      (bcd_value),
        .tick           (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          div;
        r   = '0;
        div = 1;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'((v / div) % 10);
            div = div * 10;
        end
        return r;
    endfunction

    // Advance the decimal model by one step and queue the tick it implies.
    task automatic expect_tick(input int at);
        model_v = count_down ? (model_v + 9999) % 10000 : (model_v + 1) % 10000;
        q.push_back('{at, to_bcd(model_v)});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int c, input int n, input logic down);
        int base;
        count_down     = down;
        compare_in     = 24'(c);
        update_compare = 1'b1;
        count_en       = 1'b1;
        step(1);
        update_compare = 1'b0;
        base = cyc;
        for (int i = 1; i <= n; i++) expect_tick(base + (c + 1) * i);
        step((c + 1) * n);
        count_en = 1'b0;
        step(1);
        check("drain", q.size(), 0);
        check("bcd_after_run", bcd_value, to_bcd(model_v));
    endtask

    always @(negedge clk) begin
        if (!rst && tick === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_tick", cyc, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("tick_cycle", cyc, e.at);
                check("tick_value", bcd_value, e.val);
            end
        end
    end

    initial begin
        int         base;
        int         found;
        logic [3:0] prev;
        logic [3:0] exp_sel;
        int         mux_digits [0:3] = '{4, 3, 2, 1};

        step(3);
        check("rst_bcd", bcd_value, 16'h0000);
        check("rst_sel", digit_sel, 4'b0001);
        check("rst_led", led_out, 7'b0111111);
        check("rst_tick", tick, 1'b0);

        // Release with the default compare of 7: ticks every 8 cycles.
        rst      = 1'b0;
        count_en = 1'b1;
        base     = cyc;
        expect_tick(base + 8);
        expect_tick(base + 16);
        step(18);
        check("drain_default", q.size(), 0);

        // Reset mid-count clears immediately.
        rst = 1'b1;
        #1;
        check("midrst_bcd", bcd_value, 16'h0000);
        check("midrst_sel", digit_sel, 4'b0001);
        check("midrst_led", led_out, 7'b0111111);
        check("midrst_tick", tick, 1'b0);
        count_en = 1'b0;
        step(2);
        rst     = 1'b0;
        model_v = 0;
        step(2);

        run_ticks(3, 3, 1'b0);
        check("prescale_3", bcd_value, 16'h0003);
        run_ticks(0, 7, 1'b0);
        check("carry_10", bcd_value, 16'h0010);
        run_ticks(0, 90, 1'b0);
        check("carry_100", bcd_value, 16'h0100);

        clear = 1'b1;
        step(1);
        clear   = 1'b0;
        model_v = 0;
        check("clear", bcd_value, 16'h0000);

        run_ticks(0, 1, 1'b1);
        check("down_wrap", bcd_value, 16'h9999);
        run_ticks(0, 1, 1'b0);
        check("up_wrap", bcd_value, 16'h0000);
        run_ticks(0, 10, 1'b0);
        run_ticks(0, 1, 1'b1);
        check("borrow", bcd_value, 16'h0009);

        // Clear plus reload on a terminal cycle, then reload alone on one.
        count_down     = 1'b0;
        compare_in     = 24'd2;
        update_compare = 1'b1;
        count_en       = 1'b1;
        step(1);
        update_compare = 1'b0;
        base = cyc;
        expect_tick(base + 3);
        expect_tick(base + 6);
        step(8);
        clear          = 1'b1;
        update_compare = 1'b1;
        compare_in     = 24'd5;
        step(1);
        clear          = 1'b0;
        update_compare = 1'b0;
        model_v        = 0;
        check("sim_clear_bcd", bcd_value, 16'h0000);
        check("sim_clear_tick", tick, 1'b0);
        expect_tick(base + 15);
        step(11);
        update_compare = 1'b1;
        step(1);
        update_compare = 1'b0;
        check("upd_terminal_tick", tick, 1'b0);
        check("upd_terminal_bcd", bcd_value, 16'h0001);
        expect_tick(base + 27);
        step(6);
        count_en = 1'b0;
        step(1);
        check("drain_sim", q.size(), 0);

        // Build 1234 and watch the multiplexed display.
        clear = 1'b1;
        step(1);
        clear   = 1'b0;
        model_v = 0;
        run_ticks(0, 1234, 1'b0);
        check("mux_value", bcd_value, 16'h1234);
        found = 0;
        prev  = digit_sel;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (prev != 4'b0001 && digit_sel == 4'b0001) found = 1;
            prev = digit_sel;
        end
        check("mux_sync", found, 1);
        for (int j = 0; j < 16; j++) begin
            exp_sel = 4'b0001 << (j / 4);
            check("mux_sel", digit_sel, exp_sel);
            check("mux_led", led_out, seg_tab[mux_digits[j / 4]]);
            @(negedge clk);
        end

        // Gate off while counting continues underneath.
        step(1);
        active         = 1'b0;
        compare_in     = 24'd0;
        update_compare = 1'b1;
        count_en       = 1'b1;
        step(1);
        update_compare = 1'b0;
        step(2);
        @(negedge clk);
        check("gate_led", led_out, 7'b0000000);
        check("gate_sel", digit_sel, 4'b0000);
        check("gate_bcd", bcd_value, 16'h0000);
        check("gate_tick", tick, 1'b0);
        step(3);
        count_en = 1'b0;
        model_v  = model_v + 5;
        step(1);
        active = 1'b1;
        #1;
        check("gate_counted", bcd_value, to_bcd(model_v));
        check("gate_counted_abs", bcd_value, 16'h1239);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
